// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and defaults for the clock divider bank
package clk_div_pkg;

  typedef enum logic {
    TOGGLE = 1'b0,
    PULSE  = 1'b1
  } div_mode_e;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_DIV_VAL = 9;

endpackage

// File: rtl/clk_div_bank_if.sv
// rtl/clk_div_bank_if.sv - configuration handshake bundle for the divider bank
interface clk_div_bank_if
  import clk_div_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [3:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_mode;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    output cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    input  cfg_mode,
    output cfg_ready
  );

endinterface

// File: rtl/clk_div_channel.sv
// rtl/clk_div_channel.sv - one divider channel: counter, active/shadow divisor
// and mode, pending flag, registered clk_out and tick.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DEF_DIV = DEF_DIV_VAL
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  input  logic             load_mode,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] sh_div_q, sh_div_d;
  div_mode_e        mode_q, mode_d;
  div_mode_e        sh_mode_q, sh_mode_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;
  logic             terminal;
  logic             restart;

  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    mode_d    = mode_q;
    sh_div_d  = sh_div_q;
    sh_mode_d = sh_mode_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;
    pend_d    = pend_q;
    terminal  = en && !sync && (cnt_q == div_q);
    restart   = !en || sync || terminal;

    if (!en || sync) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (terminal) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      clk_d  = (mode_q == TOGGLE) ? !clk_q : 1'b0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Shadow swaps only where a fresh count begins, so a period is never cut short.
    if (restart && pend_q) begin
      div_d  = sh_div_q;
      mode_d = sh_mode_q;
      pend_d = 1'b0;
      if (sh_mode_q == PULSE) begin
        clk_d = 1'b0;
      end
    end

    if (load) begin
      sh_div_d  = load_div;
      sh_mode_d = load_mode ? PULSE : TOGGLE;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      cnt_q     <= '0;
      div_q     <= CNT_W'(DEF_DIV);
      mode_q    <= TOGGLE;
      sh_div_q  <= CNT_W'(DEF_DIV);
      sh_mode_q <= TOGGLE;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      mode_q    <= mode_d;
      sh_div_q  <= sh_div_d;
      sh_mode_q <= sh_mode_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
      pend_q    <= pend_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pending = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of N_CH programmable clock dividers; top level
// only decodes the target channel and muxes cfg_ready.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DEF_DIV = DEF_DIV_VAL
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic [N_CH-1:0] en,
  input  logic            sync,
  clk_div_bank_if.slave   cfg,
  output logic [N_CH-1:0] clk_out,
  output logic [N_CH-1:0] tick,
  output logic [N_CH-1:0] pending
);

  logic            cfg_rdy;
  logic [N_CH-1:0] load;

  // Out-of-range channel indices leave ready high so such transfers drain harmlessly.
  always_comb begin
    cfg_rdy = 1'b1;
    load    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(cfg.cfg_ch) == i) begin
        cfg_rdy = !pending[i];
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      load[i] = cfg.cfg_valid && cfg_rdy && (int'(cfg.cfg_ch) == i);
    end
  end

  assign cfg.cfg_ready = cfg_rdy;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk_in    (clk_in),
      .rst       (rst),
      .en        (en[g]),
      .sync      (sync),
      .load      (load[g]),
      .load_div  (cfg.cfg_div),
      .load_mode (cfg.cfg_mode),
      .clk_out   (clk_out[g]),
      .tick      (tick[g]),
      .pending   (pending[g])
    );
  end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of independent divider channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of each channel's counter and divisor.
REQ-003 The block SHALL have parameter DEF_DIV, default 9, meaning the terminal count loaded into every channel at reset.
REQ-004 The block SHALL have port clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port en  input  N_CH  per-channel run enable.
REQ-007 The block SHALL have port sync  input  1  one-cycle phase-align strobe for all enabled channels.
REQ-008 The block SHALL have port cfg_valid  input  1  configuration request.
REQ-009 The block SHALL have port cfg_ready  output  1  configuration accept; the transfer occurs when cfg_valid and cfg_ready are both high at a rising edge.
REQ-010 The block SHALL have port cfg_ch  input  4  target channel index.
REQ-011 The block SHALL have port cfg_div  input  CNT_W  new terminal count D.
REQ-012 The block SHALL have port cfg_mode  input  1  0 = TOGGLE (square wave), 1 = PULSE (one-cycle tick).
REQ-013 The block SHALL have port clk_out  output  N_CH  registered divided-clock outputs.
REQ-014 The block SHALL have port tick  output  N_CH  registered one-cycle terminal-count pulses.
REQ-015 The block SHALL have port pending  output  N_CH  per channel: a configuration is accepted but not yet applied.

Function
REQ-016 Each enabled channel SHALL count 0..D, and at the edge where counter == D it SHALL reload 0 (a terminal event).
REQ-017 In TOGGLE mode, clk_out[i] SHALL invert at every terminal event, giving period 2(D+1) input cycles at 50% duty; D=9 gives divide-by-20.
REQ-018 In PULSE mode, clk_out[i] SHALL be 0, and tick[i] SHALL be high for exactly the one cycle following each terminal event, giving period D+1.
REQ-019 In TOGGLE mode, tick[i] SHALL also pulse on every terminal event.
REQ-020 D=0 SHALL be legal: TOGGLE toggles every cycle; PULSE holds tick high continuously.
REQ-021 cfg_ready SHALL be combinationally equal to NOT pending[cfg_ch] when cfg_ch < N_CH, and SHALL be 1 otherwise.
REQ-022 A transfer with cfg_ch >= N_CH SHALL be discarded without side effect.
REQ-023 An accepted transfer SHALL latch cfg_div/cfg_mode into the channel's shadow register and set pending[i] on the next cycle.
REQ-024 The shadow register SHALL apply at the channel's next terminal event, or on the next edge if en[i]=0, and pending[i] SHALL clear on the same edge.
REQ-025 The new D SHALL govern the count that starts at that edge; the in-progress period is never truncated.
REQ-026 When a mode change to PULSE applies, clk_out[i] SHALL be forced to 0 on the applying edge.
REQ-027 With en[i]=0, the channel SHALL hold counter=0, clk_out[i]=0, and tick[i]=0.
REQ-028 After en[i] rises, the first terminal event SHALL occur D+1 cycles later.
REQ-029 sync=1 SHALL, on that edge, set every enabled channel's counter to 0, clk_out to 0, and tick to 0, and SHALL apply any pending shadow.
REQ-030 sync SHALL take priority over a coincident terminal event, which then produces no toggle and no tick.
REQ-031 Counter arithmetic SHALL be unsigned CNT_W bits and never exceed D.
REQ-032 A divisor reduced below the current count SHALL be impossible by construction (REQ-024).

Reset
REQ-033 While rst=0 at a rising edge, all counters SHALL be set to 0, clk_out=0, tick=0, pending=0, divisors=DEF_DIV, and modes=TOGGLE.
REQ-034 cfg_ready SHALL read 1 from the first cycle after reset.
REQ-035 Reset SHALL override en, sync, and cfg, and an accepted but unapplied configuration SHALL be lost.
REQ-036 Reset asserted mid-period SHALL abandon the period, with no partial tick.

Structure
REQ-037 Package clk_div_pkg SHALL hold the mode enum (TOGGLE, PULSE), the default CNT_W, and the default DEF_DIV.
REQ-038 Sub-module clk_div_channel SHALL implement one channel (counter, active/shadow D and mode, pending, clk_out, tick), instantiated N_CH times.
REQ-039 The top level SHALL own only cfg_ch decode and cfg_ready muxing.

Verification
REQ-040 Reset release with en=4'b0001 and defaults SHALL make clk_out[0] toggle every 10 cycles (period 20) and tick[0] pulse every 10 cycles, with the other channels held at 0.
REQ-041 cfg to ch1 of D=3, PULSE, while running at D=9 SHALL set pending[1]=1, leave the current period at full length, then clear pending and make tick[1] pulse every 4 cycles with clk_out[1]=0.
REQ-042 A second cfg to ch1 while pending[1]=1 SHALL see cfg_ready=0 and no overwrite of the shadow, while a cfg to ch2 in the same state SHALL see cfg_ready=1.
REQ-043 sync on the same cycle as a ch0 terminal event SHALL produce no tick[0] and clk_out[0]=0, and all enabled channels SHALL then be phase-aligned.
REQ-044 D=0 in PULSE mode SHALL hold tick high continuously; D=0 in TOGGLE mode SHALL make clk_out a divide-by-2.
REQ-045 rst low mid-period with a pending config SHALL restore all outputs to 0, pending to 0, and D to 9, and the next run SHALL use period 20.
